// File: rtl/l2_backing_memory.sv
// rtl/l2_backing_memory.sv - behavioural word-array main memory behind the L2 memory port
`timescale 1ns/1ps
module l2_backing_memory #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MEM_DEPTH     = 1024,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_ready,
    output logic                  mem_hit
);
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int MAX_LAT    = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W      = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RELEASE} state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ERR} op_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    op_t                   op;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  in_range;
    logic                  accept;
    logic                  respond;
    logic                  commit_write;

    assign word_idx     = addr_q >> BYTE_SHIFT;
    assign in_range     = word_idx < ADDR_WIDTH'(MEM_DEPTH);
    assign commit_write = respond && (op == OP_WRITE) && in_range;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        respond    = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_read || mem_write) begin
                    accept     = 1'b1;
                    state_next = S_WAIT;
                    // Only a pure write uses the write latency; the error op times like a read.
                    cnt_next   = (mem_write && !mem_read) ? CNT_W'(WRITE_LATENCY - 1)
                                                          : CNT_W'(READ_LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    respond    = 1'b1;
                    state_next = S_RELEASE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            S_RELEASE: begin
                if (!mem_read && !mem_write) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op        <= OP_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_ready <= 1'b0;
            mem_hit   <= 1'b0;
            mem_rdata <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            mem_ready <= respond;
            mem_hit   <= respond && in_range && (op != OP_ERR);
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                if (mem_read && mem_write) op <= OP_ERR;
                else if (mem_write)        op <= OP_WRITE;
                else                       op <= OP_READ;
            end
            // Writes leave mem_rdata untouched so the last read value stays visible.
            if (respond) begin
                if (op == OP_READ)
                    mem_rdata <= in_range ? mem[word_idx[IDX_W-1:0]] : '0;
                else if (op == OP_ERR)
                    mem_rdata <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit_write) mem[word_idx[IDX_W-1:0]] <= wdata_q;
    end
endmodule

// File: tb/tb_l2_backing_memory.sv
// tb/tb_l2_backing_memory.sv - randomized and directed checks of l2_backing_memory against a word-array model
`timescale 1ns/1ps
module tb_l2_backing_memory;
    localparam int RL    = 4;
    localparam int WL    = 4;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_hit;

    int tests = 0;
    int fails = 0;

    logic [31:0] model_mem   [DEPTH];
    bit          model_valid [DEPTH];
    logic [31:0] exp_rd = '0;
    bit          exp_known = 1'b1;

    l2_backing_memory #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_hit(mem_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request: returns data/status sampled in the ready cycle and edges from accept to ready.
    task automatic xact(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input bit drop_early, output logic [31:0] rdata, output logic hit, output int lat);
        int  n;
        bit  seen;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wd;
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                mem_addr = $urandom; mem_wdata = $urandom;
                if (drop_early) begin mem_read = 0; mem_write = 0; end
            end
            if (mem_ready) seen = 1;
        end
        rdata = mem_rdata; hit = mem_hit; lat = seen ? n - 1 : -1;
        mem_read = 0; mem_write = 0;
        @(posedge clk); #1;
        check("ready_drop", 32'(mem_ready), 32'd0);
        check("hit_drop", 32'(mem_hit), 32'd0);
    endtask

    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input bit drop_early);
        logic [31:0] r;
        logic        h;
        int          lat;
        bit          inr;
        int          idx;
        inr = (addr >> 2) < DEPTH;
        idx = inr ? int'(addr >> 2) : 0;
        xact(rd, wr, addr, wd, drop_early, r, h, lat);
        check("latency", lat, (wr && !rd) ? WL : RL);
        if (rd && wr) begin
            check("err_hit", 32'(h), 32'd0);
            check("err_rdata", r, 32'd0);
            exp_rd = '0; exp_known = 1;
        end else if (rd) begin
            check("rd_hit", 32'(h), 32'(inr));
            if (!inr) begin
                check("rd_oor_rdata", r, 32'd0);
                exp_rd = '0; exp_known = 1;
            end else if (model_valid[idx]) begin
                check("rd_data", r, model_mem[idx]);
                exp_rd = model_mem[idx]; exp_known = 1;
            end else begin
                exp_known = 0;
            end
        end else begin
            check("wr_hit", 32'(h), 32'(inr));
            if (exp_known) check("wr_rdata_hold", r, exp_rd);
            if (inr) begin model_mem[idx] = wd; model_valid[idx] = 1; end
        end
    endtask

    initial begin
        int pulses;
        bit prev;
        logic [31:0] a;
        int k;

        #12;
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_hit", 32'(mem_hit), 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        @(negedge clk); rst_n = 1;

        do_op(0, 1, 32'h40, 32'hDEADBEEF, 0);
        do_op(1, 0, 32'h40, 32'h0, 0);
        do_op(0, 1, 32'h103, 32'h12345678, 0);
        do_op(1, 0, 32'h100, 32'h0, 0);

        do_op(0, 1, 32'h0, 32'hCAFEF00D, 0);
        do_op(1, 0, 32'h1000, 32'h0, 0);
        do_op(0, 1, 32'h1000, 32'h55555555, 0);
        do_op(1, 0, 32'h0, 32'h0, 0);

        do_op(0, 1, 32'h40, 32'hA5A5A5A5, 0);
        do_op(1, 1, 32'h40, 32'h0, 0);
        do_op(1, 0, 32'h40, 32'h0, 0);

        // Held request: exactly one pulse for 20 cycles of mem_read.
        @(negedge clk); mem_read = 1; mem_addr = 32'h40;
        pulses = 0; prev = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (mem_ready && !prev) pulses++;
            prev = mem_ready;
        end
        mem_read = 0;
        check("held_pulses", pulses, 32'd1);
        @(posedge clk);
        do_op(1, 0, 32'h40, 32'h0, 0);

        // Request dropped right after accept still completes.
        do_op(1, 0, 32'h100, 32'h0, 1);
        do_op(0, 1, 32'h44, 32'h0BADC0DE, 1);
        do_op(1, 0, 32'h44, 32'h0, 0);

        // Reset two cycles into a write must abort it with outputs cleared immediately.
        do_op(0, 1, 32'h80, 32'h22222222, 0);
        do_op(1, 0, 32'h80, 32'h0, 0);
        @(negedge clk); mem_write = 1; mem_addr = 32'h80; mem_wdata = 32'h11111111;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        rst_n = 0;
        #2;
        check("midrst_ready", 32'(mem_ready), 32'd0);
        check("midrst_hit", 32'(mem_hit), 32'd0);
        check("midrst_rdata", mem_rdata, 32'd0);
        @(negedge clk); mem_write = 0; rst_n = 1;
        exp_rd = '0; exp_known = 1;
        do_op(1, 0, 32'h80, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0)
                a = 32'h1000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            else
                a = ($urandom_range(0, 31) << 2) + $urandom_range(0, 3);
            if (k < 4)       do_op(1, 0, a, 32'h0, 0);
            else if (k < 8)  do_op(0, 1, a, $urandom, 0);
            else if (k == 8) do_op(1, 1, a, $urandom, 0);
            else             do_op(1, 0, a, 32'h0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
